// File: rtl/data_mem_align_unit.sv
// data_mem_align_unit: maps left-justified LSU byte accesses onto a word-wide,
// byte-enabled synchronous RAM. Word-crossing accesses become two RAM accesses,
// and load bytes are gathered back left-justified.
// Ports: LSU request (to_mem_*, mem_*), LSU response (from_mem_*, mem_read_data*),
// RAM port (ram_*). Define DMEM_ALIGN_ERR_EN to add misalign_err and reject
// crossing accesses instead of splitting them.
module data_mem_align_unit #(
  parameter int READ_LATENCY   = 1,
  parameter int RAM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      to_mem_valid,
  output logic                      to_mem_ready,
  input  logic [31:0]               mem_address,
  input  logic [3:0]                mem_write_en,
  input  logic [31:0]               mem_write_data,
  input  logic [3:0]                mem_read_en,
  output logic                      from_mem_valid,
  input  logic                      from_mem_ready,
  output logic [31:0]               mem_read_data,
  output logic                      mem_read_data_valid,
  output logic                      ram_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]                ram_we,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata
`ifdef DMEM_ALIGN_ERR_EN
  ,
  output logic                      misalign_err
`endif
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int RL = READ_LATENCY;
  localparam int CW = (RL > 1) ? $clog2(RL) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            store_q, store_d;
  logic            load_q, load_d;
  logic            split_q, split_d;
  logic            err_q, err_d;
  logic [1:0]      off_q, off_d;
  logic [3:0]      ren_q, ren_d;
  logic [7:0]      mask_q, mask_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [AW-1:0]   word_q, word_d;
  logic [31:0]     word0_q, word0_d;
  logic [31:0]     word1_q, word1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RL-1:0]   pipe_v_q, pipe_v_d;
  logic [RL-1:0]   pipe_s_q, pipe_s_d;

  logic            accept;
  logic            acc_store;
  logic            acc_load;
  logic            acc_split;
  logic [3:0]      acc_en;
  logic [7:0]      acc_mask;
  logic [63:0]     acc_data;
  logic            issue;
  logic            issue_slot;
  logic            resp_load;
  logic [63:0]     cat;
  logic [5:0]      top;
  logic [31:0]     rmask;
  logic            unused_addr;

  assign to_mem_ready = rst && (state_q == S_IDLE);
  assign accept       = to_mem_valid && to_mem_ready;
  assign acc_store    = |mem_write_en;
  assign acc_load     = !acc_store && (|mem_read_en);
  assign acc_en       = acc_store ? mem_write_en : mem_read_en;
  // 8-lane window: lanes 0-3 hit word W, lanes 4-7 spill into W+1
  assign acc_mask     = {acc_en, 4'b0000} >> mem_address[1:0];
  assign acc_split    = |acc_mask[3:0];
  assign acc_data     = {mem_write_data, 32'h0}
                        >> {mem_address[1:0], 3'b000};
  assign unused_addr  = ^mem_address[31:AW+2];

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    load_d     = load_q;
    split_d    = split_q;
    err_d      = err_q;
    off_d      = off_q;
    ren_d      = ren_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    word0_d    = word0_q;
    word1_d    = word1_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    issue_slot = 1'b0;
    ram_en     = 1'b0;
    ram_addr   = '0;
    ram_we     = 4'b0000;
    ram_wdata  = 32'h0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          store_d = acc_store;
          load_d  = acc_load;
          split_d = acc_split;
          err_d   = 1'b0;
          off_d   = mem_address[1:0];
          ren_d   = mem_read_en;
          mask_d  = acc_mask;
          wdata_d = acc_data;
          word_d  = mem_address[AW+1:2];
          word0_d = 32'h0;
          word1_d = 32'h0;
          if (!acc_store && !acc_load) begin
            state_d = S_RESP;
`ifdef DMEM_ALIGN_ERR_EN
          end else if (acc_split) begin
            err_d   = 1'b1;
            state_d = S_RESP;
`endif
          end else begin
            state_d = S_ACC0;
          end
        end
      end
      S_ACC0: begin
        ram_en     = 1'b1;
        ram_addr   = word_q;
        ram_we     = store_q ? mask_q[7:4] : 4'b0000;
        ram_wdata  = wdata_q[63:32];
        issue      = load_q;
        issue_slot = 1'b0;
        if (split_q) begin
          state_d = S_ACC1;
        end else if (load_q) begin
          state_d = S_WAIT;
          cnt_d   = CW'(RL - 1);
        end else begin
          state_d = S_RESP;
        end
      end
      S_ACC1: begin
        ram_en     = 1'b1;
        ram_addr   = word_q + 1'b1;
        ram_we     = store_q ? mask_q[3:0] : 4'b0000;
        ram_wdata  = wdata_q[31:0];
        issue      = load_q;
        issue_slot = 1'b1;
        if (load_q) begin
          state_d = S_WAIT;
          cnt_d   = CW'(RL - 1);
        end else begin
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (from_mem_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // read tags travel RL cycles so each word lands when the RAM delivers it
    pipe_v_d[0] = issue;
    pipe_s_d[0] = issue_slot;
    for (int i = 1; i < RL; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_s_d[i] = pipe_s_q[i-1];
    end
    if (pipe_v_q[RL-1]) begin
      if (pipe_s_q[RL-1]) begin
        word1_d = ram_rdata;
      end else begin
        word0_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      load_q   <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      off_q    <= 2'b00;
      ren_q    <= 4'b0000;
      mask_q   <= 8'h00;
      wdata_q  <= 64'h0;
      word_q   <= '0;
      word0_q  <= 32'h0;
      word1_q  <= 32'h0;
      cnt_q    <= '0;
      pipe_v_q <= '0;
      pipe_s_q <= '0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      load_q   <= load_d;
      split_q  <= split_d;
      err_q    <= err_d;
      off_q    <= off_d;
      ren_q    <= ren_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      word0_q  <= word0_d;
      word1_q  <= word1_d;
      cnt_q    <= cnt_d;
      pipe_v_q <= pipe_v_d;
      pipe_s_q <= pipe_s_d;
    end
  end

  assign from_mem_valid      = (state_q == S_RESP);
  assign resp_load           = from_mem_valid && load_q && !err_q;
  assign mem_read_data_valid = resp_load;

  // {word0,word1} shifted left by the byte offset, top 32 bits kept
  assign cat   = {word0_q, word1_q};
  assign top   = 6'd63 - {1'b0, off_q, 3'b000};
  assign rmask = {{8{ren_q[3]}}, {8{ren_q[2]}},
                  {8{ren_q[1]}}, {8{ren_q[0]}}};
  assign mem_read_data = resp_load ? (cat[top -: 32] & rmask) : 32'h0;

`ifdef DMEM_ALIGN_ERR_EN
  assign misalign_err = from_mem_valid && err_q;
`endif

endmodule

// File: tb/tb_data_mem_align_unit.sv
// Bench for data_mem_align_unit: byte-addressed reference memory model,
// a behavioural RAM, and one per-cycle compare process.
module tb_data_mem_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        to_mem_valid;
  logic        to_mem_ready;
  logic [31:0] mem_address;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_read_en;
  logic        from_mem_valid;
  logic        from_mem_ready;
  logic [31:0] mem_read_data;
  logic        mem_read_data_valid;
  logic        ram_en;
  logic [11:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  data_mem_align_unit #(
    .READ_LATENCY   (1),
    .RAM_ADDR_WIDTH (12)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .to_mem_valid        (to_mem_valid),
    .to_mem_ready        (to_mem_ready),
    .mem_address         (mem_address),
    .mem_write_en        (mem_write_en),
    .mem_write_data      (mem_write_data),
    .mem_read_en         (mem_read_en),
    .from_mem_valid      (from_mem_valid),
    .from_mem_ready      (from_mem_ready),
    .mem_read_data       (mem_read_data),
    .mem_read_data_valid (mem_read_data_valid),
    .ram_en              (ram_en),
    .ram_addr            (ram_addr),
    .ram_we              (ram_we),
    .ram_wdata           (ram_wdata),
    .ram_rdata           (ram_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] ram   [4096];
  logic [7:0]  ref_b [16384];

  int          exp_lat;
  int          exp_nacc;
  logic [31:0] exp_rd;
  logic        exp_rdv;

  int          t_acc;
  int          n_acc;
  logic        active = 1'b0;
  logic        got;
  logic [11:0] acc_addr  [2];
  logic [3:0]  acc_we    [2];
  logic [31:0] acc_wdata [2];
  logic [31:0] mon_rd;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic poke(input int w, input logic [31:0] v);
    ram[w] = v;
    for (int l = 0; l < 4; l++) ref_b[4*w+l] = v[31-8*l -: 8];
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w], ref_b[4*w+1], ref_b[4*w+2], ref_b[4*w+3]};
  endfunction

  task automatic tick();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic ram_model();
    forever begin
      @(posedge clk);
      if (ram_en) begin
        ram_rdata <= ram[ram_addr];
        for (int l = 0; l < 4; l++)
          if (ram_we[3-l])
            ram[ram_addr][31-8*l -: 8] = ram_wdata[31-8*l -: 8];
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 1'b0;
      end else begin
        if (to_mem_valid && to_mem_ready) begin
          t_acc  = cyc;
          n_acc  = 0;
          got    = 1'b0;
          active = 1'b1;
        end
        if (ram_en && active) begin
          if (n_acc < 2) begin
            acc_addr[n_acc]  = ram_addr;
            acc_we[n_acc]    = ram_we;
            acc_wdata[n_acc] = ram_wdata;
          end
          n_acc++;
        end
        if (from_mem_valid) begin
          if (!active) begin
            chk("unexpected_resp", 64'(from_mem_valid), 64'd0);
          end else begin
            chk("rdata", mem_read_data, exp_rd);
            chk("rdv", mem_read_data_valid, exp_rdv);
            if (!got) begin
              chk("latency", 64'(cyc - t_acc), 64'(exp_lat));
              chk("ram_accesses", 64'(n_acc), 64'(exp_nacc));
              mon_rd = mem_read_data;
              got    = 1'b1;
            end
            if (from_mem_ready) active = 1'b0;
          end
        end
      end
    end
  endtask

  // called at posedge+2 with the DUT idle; returns at posedge+2, idle again
  task automatic do_req(input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input logic [3:0] re,
                        input int hold);
    logic [3:0]  en;
    logic        st;
    logic        ld;
    logic        sp;
    logic [13:0] ba;
    logic        done;
    int          w0;
    st = |we;
    ld = !st && (|re);
    en = st ? we : (ld ? re : 4'b0000);
    sp = 1'b0;
    exp_rd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ba = a[13:0] + 14'(i);
      if (en[3-i] && (int'(a[1:0]) + i > 3)) sp = 1'b1;
      if (ld && re[3-i]) exp_rd[31-8*i -: 8] = ref_b[ba];
      if (st && we[3-i]) ref_b[ba] = wd[31-8*i -: 8];
    end
    exp_rdv  = ld;
    exp_nacc = (st || ld) ? 1 + int'(sp) : 0;
    exp_lat  = !(st || ld) ? 1 : (st ? 2 + int'(sp) : 3 + int'(sp));
    from_mem_ready = (hold == 0);
    mem_address    = a;
    mem_write_en   = we;
    mem_write_data = wd;
    mem_read_en    = re;
    to_mem_valid   = 1'b1;
    @(posedge clk);
    #2;
    to_mem_valid   = 1'b0;
    mem_address    = 32'h0;
    mem_write_en   = 4'h0;
    mem_write_data = 32'h0;
    mem_read_en    = 4'h0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (from_mem_valid && !from_mem_ready) begin
        for (int s = 0; s < hold; s++) begin
          chk("stall_valid", from_mem_valid, 1);
          chk("stall_ready", to_mem_ready, 0);
          chk("stall_ram_en", ram_en, 0);
          @(negedge clk);
        end
        @(posedge clk);
        #2;
        from_mem_ready = 1'b1;
      end else if (from_mem_valid && from_mem_ready) begin
        done = 1'b1;
      end
    end
    chk("resp_timeout", done, 1);
    if (st) begin
      w0 = int'(a[13:2]);
      chk("store_word0", ram[w0], ref_word(w0));
      if (sp) chk("store_word1", ram[(w0+1)%4096], ref_word((w0+1)%4096));
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst            = 1'b0;
    to_mem_valid   = 1'b0;
    mem_address    = 32'h0;
    mem_write_en   = 4'h0;
    mem_write_data = 32'h0;
    mem_read_en    = 4'h0;
    from_mem_ready = 1'b1;
    ram_rdata      = 32'h0;
    for (int w = 0; w < 4096; w++) poke(w, w * 32'h9E3779B9);
    fork
      tick();
      ram_model();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_to_mem_ready", to_mem_ready, 0);
    chk("rst_from_mem_valid", from_mem_valid, 0);
    chk("rst_rdv", mem_read_data_valid, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_read_data", mem_read_data, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", to_mem_ready, 1);
    @(posedge clk);
    #2;

    do_req(32'h100, 4'b1111, 32'hDEADBEEF, 4'b0000, 0);
    chk("t1_addr", acc_addr[0], 12'h040);
    chk("t1_we", acc_we[0], 4'b1111);
    chk("t1_ram", ram[12'h040], 32'hDEADBEEF);

    poke(12'h040, 32'h11223344);
    do_req(32'h103, 4'b0000, 32'h0, 4'b1000, 0);
    chk("t2_data", mon_rd, 32'h44000000);

    do_req(32'h107, 4'b1100, 32'hABCD0000, 4'b0000, 0);
    chk("t3_addr0", acc_addr[0], 12'h041);
    chk("t3_addr1", acc_addr[1], 12'h042);
    chk("t3_we0", acc_we[0], 4'b0001);
    chk("t3_we1", acc_we[1], 4'b1000);
    chk("t3_lane3", acc_wdata[0][7:0], 8'hAB);
    chk("t3_lane0", acc_wdata[1][31:24], 8'hCD);

    poke(12'h040, 32'h00112233);
    poke(12'h041, 32'h44556677);
    do_req(32'h102, 4'b0000, 32'h0, 4'b1111, 0);
    chk("t4_data", mon_rd, 32'h22334455);

    poke(12'hFFF, 32'h01020399);
    poke(12'h000, 32'hABCDEF01);
    do_req(32'h3FFF, 4'b0000, 32'h0, 4'b1100, 0);
    chk("t5_addr0", acc_addr[0], 12'hFFF);
    chk("t5_addr1", acc_addr[1], 12'h000);
    chk("t5_data", mon_rd, 32'h99AB0000);

    do_req(32'h55, 4'b0000, 32'h12345678, 4'b0000, 0);

    do_req(32'h12E, 4'b0010, 32'h00005A00, 4'b0000, 0);
    chk("spill_we0", acc_we[0], 4'b0000);
    chk("spill_we1", acc_we[1], 4'b1000);
    do_req(32'h130, 4'b0000, 32'h0, 4'b1111, 0);
    chk("spill_readback", mon_rd[31:24], 8'h5A);

    do_req(32'h300, 4'b0110, 32'h00C0FF00, 4'b1111, 0);
    do_req(32'hFFFF0300, 4'b0000, 32'h0, 4'b1111, 0);
    chk("hi_addr_data", mon_rd[23:8], 16'hC0FF);
    do_req(32'h101, 4'b0000, 32'h0, 4'b0101, 0);

    do_req(32'h108, 4'b0000, 32'h0, 4'b1111, 10);

    exp_rd         = 32'h0;
    exp_rdv        = 1'b1;
    exp_lat        = 3;
    exp_nacc       = 1;
    mem_address    = 32'h200;
    mem_read_en    = 4'b1111;
    to_mem_valid   = 1'b1;
    @(posedge clk);
    #2;
    to_mem_valid   = 1'b0;
    mem_address    = 32'h0;
    mem_read_en    = 4'h0;
    rst            = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("abort_ready", to_mem_ready, 0);
    chk("abort_valid", from_mem_valid, 0);
    chk("abort_ram_en", ram_en, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", to_mem_ready, 1);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_resp", from_mem_valid, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    do_req(32'h201, 4'b0000, 32'h0, 4'b1110, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
